// File: rtl/btn_event_pkg.sv
// Shared codes for the button event controller: event types and per-button FSM states.
// Pure declarations; no logic, no latency, no backpressure.
package btn_event_pkg;

  typedef enum logic [1:0] {
    EV_PRESS  = 2'd0,
    EV_CLICK  = 2'd1,
    EV_LONG   = 2'd2,
    EV_REPEAT = 2'd3
  } ev_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    RPT  = 2'd2
  } btn_state_e;

endpackage

// File: rtl/btn_press_fsm.sv
// Classifies one debounced button into PRESS / CLICK / LONG / REPEAT events.
// Latency: emit is combinational in the cycle the edge or tick is seen.
// Backpressure: none; the caller decides whether an emitted event is kept.
module btn_press_fsm
  import btn_event_pkg::*;
#(
  parameter int LONG_MS = 1000,
  parameter int REP_MS  = 200,
  parameter int CNT_W   = 12
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     tick,
  input  logic     btn,
  output logic     emit,
  output ev_type_e ev_type
);

  localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REP_TH  = CNT_W'(REP_MS - 1);

  btn_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             btn_q;
  logic             rise, fall;

  // btn_q resets low so a button still held after reset is seen as a fresh rise.
  assign rise = btn & ~btn_q;
  assign fall = ~btn & btn_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      btn_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      btn_q <= btn;
    end
  end

  // A release always wins over a threshold tick in the same cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    emit    = 1'b0;
    ev_type = EV_PRESS;
    case (state)
      IDLE: begin
        if (rise) begin
          emit    = 1'b1;
          ev_type = EV_PRESS;
          cnt_n   = '0;
          state_n = HELD;
        end
      end
      HELD: begin
        if (fall) begin
          emit    = 1'b1;
          ev_type = EV_CLICK;
          state_n = IDLE;
        end else if (tick) begin
          if (cnt == LONG_TH) begin
            emit    = 1'b1;
            ev_type = EV_LONG;
            cnt_n   = '0;
            state_n = RPT;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      RPT: begin
        if (fall) begin
          state_n = IDLE;
        end else if (tick) begin
          if (cnt == REP_TH) begin
            emit    = 1'b1;
            ev_type = EV_REPEAT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// N-button event controller: per-button classifiers, one-deep pending slots, round-robin onto one port.
// Latency: emit at t -> pending at t+1 -> ev_valid at t+2 when the output register is free.
// Backpressure: ev_ready low holds the output; a second event on a full slot is dropped and flagged in ovf.
module btn_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int N        = 4,
  parameter int SIM      = 0,
  parameter int TICK_DIV = 100000,
  parameter int LONG_MS  = 1000,
  parameter int REP_MS   = 200,
  parameter int CNT_W    = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         btn,
  input  logic                 ev_ready,
  output logic                 ev_valid,
  output logic [$clog2(N)-1:0] ev_id,
  output logic [1:0]           ev_type,
  input  logic                 ovf_clr,
  output logic [N-1:0]         ovf
);

  localparam int TDIV = (SIM != 0) ? 32 : TICK_DIV;
  localparam int PW   = $clog2(TDIV);
  localparam int IW   = $clog2(N);

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % N);
  endfunction

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PW'(TDIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc <= '0;
    else        presc <= tick ? '0 : presc + PW'(1);
  end

  logic [N-1:0] emit;
  ev_type_e     emit_type [N];

  for (genvar i = 0; i < N; i++) begin : g_btn
    btn_press_fsm #(
      .LONG_MS (LONG_MS),
      .REP_MS  (REP_MS),
      .CNT_W   (CNT_W)
    ) u_fsm (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .btn     (btn[i]),
      .emit    (emit[i]),
      .ev_type (emit_type[i])
    );
  end

  logic [N-1:0]  pend;
  ev_type_e      ptype [N];
  logic [IW-1:0] rr_ptr, grant, grant_nxt;
  logic          grant_vld, load;
  logic [N-1:0]  take;

  assign load = !ev_valid || ev_ready;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pend[rr_idx(rr_ptr, k)]) begin
        grant     = rr_idx(rr_ptr, k);
        grant_vld = 1'b1;
      end
    end
    grant_nxt = rr_idx(grant, 1);
    take      = '0;
    for (int i = 0; i < N; i++) begin
      take[i] = load && grant_vld && (grant == IW'(i));
    end
  end

  // A slot being emptied this cycle can accept a new event without overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
      ovf  <= '0;
      for (int i = 0; i < N; i++) ptype[i] <= EV_PRESS;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (emit[i] && (!pend[i] || take[i])) begin
          pend[i]  <= 1'b1;
          ptype[i] <= emit_type[i];
        end else if (take[i]) begin
          pend[i] <= 1'b0;
        end
        if (emit[i] && pend[i] && !take[i]) ovf[i] <= 1'b1;
        else if (ovf_clr)                   ovf[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_type  <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      if (grant_vld) begin
        ev_valid <= 1'b1;
        ev_id    <= grant;
        ev_type  <= ptype[grant];
        rr_ptr   <= grant_nxt;
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed scenarios plus random button/ready traffic,
// checked against a tick-counting event model and per-transfer scoreboard.
module tb_btn_event_ctrl;

  localparam int N    = 4;
  localparam int LONG = 10;
  localparam int REP  = 3;
  localparam int TD   = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn = 4'h0;
  logic       ev_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic [1:0] ev_type;
  logic [3:0] ovf;

  btn_event_ctrl #(
    .N(4), .SIM(1), .TICK_DIV(100000), .LONG_MS(LONG), .REP_MS(REP), .CNT_W(12)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_id(ev_id), .ev_type(ev_type),
    .ovf_clr(ovf_clr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: counts ticks seen while each button is held.
  int  edge_cnt;
  bit  prev [4];
  int  held [4];
  int  exp_id [$];
  int  exp_ty [$];
  bit  model_on;
  int  n_ty [4];

  task automatic push(input int id, input int ty);
    exp_id.push_back(id);
    exp_ty.push_back(ty);
  endtask

  task automatic model_reset();
    edge_cnt = 0;
    for (int i = 0; i < N; i++) begin
      prev[i] = 1'b0;
      held[i] = 0;
    end
    exp_id.delete();
    exp_ty.delete();
  endtask

  task automatic clear_tally();
    for (int i = 0; i < 4; i++) n_ty[i] = 0;
  endtask

  task automatic model_step();
    bit tk;
    edge_cnt++;
    tk = (edge_cnt % TD) == 0;
    for (int i = 0; i < N; i++) begin
      if (btn[i] && !prev[i]) begin
        push(i, 0);
        held[i] = 0;
      end else if (!btn[i] && prev[i]) begin
        if (held[i] < LONG) push(i, 1);
      end else if (btn[i] && tk) begin
        held[i]++;
        if (held[i] == LONG) push(i, 2);
        else if (held[i] > LONG && ((held[i] - LONG) % REP) == 0) push(i, 3);
      end
      prev[i] = btn[i];
    end
  endtask

  // One clock: score the transfer happening at this edge, advance the model, check stall stability.
  task automatic cyc();
    logic       xfer, stall;
    logic [1:0] sid, stype;
    int         found;
    xfer  = ev_valid && ev_ready;
    stall = ev_valid && !ev_ready;
    sid   = ev_id;
    stype = ev_type;
    if (xfer) begin
      n_ty[stype]++;
      if (model_on) begin
        found = -1;
        for (int j = 0; j < exp_id.size(); j++) begin
          if (exp_id[j] == int'(sid)) begin
            found = j;
            break;
          end
        end
        checks++;
        if (found < 0) begin
          errors++;
          $display("FAIL event_unexpected: got id=%0d type=%0d, expected no event for that id", sid, stype);
        end else begin
          if (exp_ty[found] !== int'(stype)) begin
            errors++;
            $display("FAIL event_type id=%0d: got type=%0d, expected %0d", sid, stype, exp_ty[found]);
          end
          exp_id.delete(found);
          exp_ty.delete(found);
        end
      end
    end
    @(posedge clk);
    model_step();
    #1;
    if (stall) begin
      checks++;
      if (ev_valid !== 1'b1 || ev_id !== sid || ev_type !== stype) begin
        errors++;
        $display("FAIL stall_stable: got v=%0b id=%0d type=%0d, expected v=1 id=%0d type=%0d",
                 ev_valid, ev_id, ev_type, sid, stype);
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    repeat (20) cyc();
    checks++;
    if (exp_id.size() !== 0) begin
      errors++;
      $display("FAIL drain_leftover: got %0d missing events, expected 0", exp_id.size());
    end
  endtask

  task automatic test_reset();
    btn = 4'h0;
    apply_reset();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, expected 0", ev_valid); end
    checks++;
    if (ev_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d, expected 0", ev_id); end
    checks++;
    if (ev_type !== 2'd0) begin errors++; $display("FAIL reset_type: got %0d, expected 0", ev_type); end
    checks++;
    if (ovf !== 4'h0) begin errors++; $display("FAIL reset_ovf: got %b, expected 0000", ovf); end
  endtask

  task automatic test_click();
    apply_reset();
    model_on = 1'b1;
    clear_tally();
    ev_ready = 1'b1;
    btn[1] = 1'b1;
    cyc();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL latency_t1: got v=%0b, expected 0", ev_valid); end
    cyc();
    checks++;
    if (ev_valid !== 1'b1 || ev_id !== 2'd1 || ev_type !== 2'd0) begin
      errors++;
      $display("FAIL latency_t2: got v=%0b id=%0d type=%0d, expected v=1 id=1 type=0", ev_valid, ev_id, ev_type);
    end
    repeat (5 * TD - 2) cyc();
    btn[1] = 1'b0;
    drain();
    checks++;
    if (n_ty[0] !== 1 || n_ty[1] !== 1 || n_ty[2] !== 0 || n_ty[3] !== 0) begin
      errors++;
      $display("FAIL click_counts: got P=%0d C=%0d L=%0d R=%0d, expected 1 1 0 0", n_ty[0], n_ty[1], n_ty[2], n_ty[3]);
    end
  endtask

  task automatic test_long();
    apply_reset();
    model_on = 1'b1;
    clear_tally();
    btn[2] = 1'b1;
    repeat (17 * TD) cyc();
    btn[2] = 1'b0;
    drain();
    checks++;
    if (n_ty[0] !== 1 || n_ty[1] !== 0 || n_ty[2] !== 1 || n_ty[3] !== 2) begin
      errors++;
      $display("FAIL long_counts: got P=%0d C=%0d L=%0d R=%0d, expected 1 0 1 2", n_ty[0], n_ty[1], n_ty[2], n_ty[3]);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    model_on = 1'b1;
    clear_tally();
    btn = 4'hF;
    cyc();
    cyc();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ev_valid !== 1'b1 || ev_id !== 2'(k) || ev_type !== 2'd0) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%0b id=%0d type=%0d, expected v=1 id=%0d type=0", k, ev_valid, ev_id, ev_type, k);
      end
      cyc();
    end
    btn = 4'h0;
    drain();
  endtask

  task automatic test_ovf();
    apply_reset();
    model_on = 1'b0;
    ev_ready = 1'b0;
    btn[0] = 1'b1;
    repeat (3) cyc();
    btn[0] = 1'b0;
    repeat (3) cyc();
    btn[0] = 1'b1;
    repeat (3) cyc();
    checks++;
    if (ev_valid !== 1'b1 || ev_id !== 2'd0 || ev_type !== 2'd0) begin
      errors++;
      $display("FAIL ovf_hold: got v=%0b id=%0d type=%0d, expected v=1 id=0 type=0", ev_valid, ev_id, ev_type);
    end
    checks++;
    if (ovf !== 4'b0001) begin errors++; $display("FAIL ovf_set: got %b, expected 0001", ovf); end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clr: got %b, expected 0000", ovf); end
    btn[0] = 1'b0;
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 4'b0001) begin errors++; $display("FAIL ovf_clr_vs_drop: got %b, expected 0001", ovf); end
    ev_ready = 1'b1;
    cyc();
    checks++;
    if (ev_valid !== 1'b1 || ev_id !== 2'd0 || ev_type !== 2'd1) begin
      errors++;
      $display("FAIL ovf_next: got v=%0b id=%0d type=%0d, expected v=1 id=0 type=1", ev_valid, ev_id, ev_type);
    end
    cyc();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got v=%0b, expected 0", ev_valid); end
  endtask

  task automatic test_fall_on_tick();
    int guard;
    apply_reset();
    model_on = 1'b1;
    clear_tally();
    btn[3] = 1'b1;
    cyc();
    guard = 0;
    while (!(held[3] == LONG - 1 && ((edge_cnt + 1) % TD) == 0) && guard < 20 * TD) begin
      cyc();
      guard++;
    end
    checks++;
    if (guard >= 20 * TD) begin errors++; $display("FAIL fall_tick_timeout: got %0d cycles, expected fewer", guard); end
    btn[3] = 1'b0;
    cyc();
    drain();
    checks++;
    if (n_ty[1] !== 1 || n_ty[2] !== 0) begin
      errors++;
      $display("FAIL fall_tick_counts: got C=%0d L=%0d, expected C=1 L=0", n_ty[1], n_ty[2]);
    end
  endtask

  task automatic test_reset_mid_press();
    apply_reset();
    model_on = 1'b0;
    ev_ready = 1'b0;
    btn[1] = 1'b1;
    repeat (11 * TD) cyc();
    checks++;
    if (ev_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got v=%0b, expected 1", ev_valid); end
    reset = 1'b0;
    #1;
    checks++;
    if (ev_valid !== 1'b0 || ev_id !== 2'd0 || ev_type !== 2'd0 || ovf !== 4'h0) begin
      errors++;
      $display("FAIL midrst_async: got v=%0b id=%0d type=%0d ovf=%b, expected all 0", ev_valid, ev_id, ev_type, ovf);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_on = 1'b1;
    clear_tally();
    ev_ready = 1'b1;
    cyc();
    cyc();
    checks++;
    if (ev_valid !== 1'b1 || ev_id !== 2'd1 || ev_type !== 2'd0) begin
      errors++;
      $display("FAIL midrst_press: got v=%0b id=%0d type=%0d, expected v=1 id=1 type=0", ev_valid, ev_id, ev_type);
    end
    btn[1] = 1'b0;
    drain();
  endtask

  task automatic test_random();
    int hold;
    apply_reset();
    model_on = 1'b1;
    clear_tally();
    for (int s = 0; s < 40; s++) begin
      btn  = 4'($urandom);
      hold = $urandom_range(700, 40);
      for (int c = 0; c < hold; c++) begin
        ev_ready = ($urandom_range(3, 0) != 0);
        cyc();
      end
    end
    btn = 4'h0;
    drain();
    checks++;
    if (ovf !== 4'h0) begin errors++; $display("FAIL random_ovf: got %b, expected 0000", ovf); end
  endtask

  initial begin
    model_on = 1'b0;
    model_reset();
    clear_tally();
    test_reset();
    test_click();
    test_long();
    test_back_to_back();
    test_ovf();
    test_fall_on_tick();
    test_reset_mid_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
